// File: rtl/nn_pkg.sv
// Shared types and helpers for the network sequencer: FSM state encoding,
// default data width and a $clog2 variant that never returns zero.
package nn_pkg;

  localparam int NN_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } nn_state_e;

  // Address/index widths must be at least one bit even for a depth of one.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nn_channel_ram.sv
// Private input-channel RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle returns the old word.
module nn_channel_ram
  import nn_pkg::*;
#(
  parameter int DATA_W = NN_DATA_W,
  parameter int DEPTH  = 2,
  parameter int ADDR_W = clog2_min1(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_word;

  // Contents survive reset so a reset never destroys a loaded vector's storage.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  if (DEPTH == (1 << ADDR_W)) begin : g_full
    assign rd_word = mem_q[raddr_i];
  end else begin : g_partial
    assign rd_word = (int'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_o <= '0;
    end else begin
      rdata_o <= rd_word;
    end
  end

endmodule

// File: rtl/nn_network_sequencer.sv
// Top-level sequencer: loads N_INPUTS values into the channel RAM, then walks
// N_LAYERS layers through one-hot req/ack pairs and reports network completion.
module nn_network_sequencer
  import nn_pkg::*;
#(
  parameter int  DATA_W   = NN_DATA_W,
  parameter int  N_INPUTS = 2,
  parameter int  N_LAYERS = 2,
  localparam int ADDR_W   = clog2_min1(N_INPUTS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fill,
  input  logic                     req,
  output logic                     ack_network,
  output logic                     loaded,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic [N_LAYERS-1:0]      layer_req,
  input  logic [N_LAYERS-1:0]      layer_ack,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_data,
  output nn_state_e                dbg_state
);

  localparam int                LIDX_W     = clog2_min1(N_LAYERS);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_INPUTS - 1);
  localparam logic [LIDX_W-1:0] LAST_LAYER = LIDX_W'(N_LAYERS - 1);

  nn_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [LIDX_W-1:0]   layer_idx_q, layer_idx_d;
  logic                loaded_q, loaded_d;
  logic                ack_q, ack_d;
  logic [N_LAYERS-1:0] layer_req_q, layer_req_d;
  logic [N_LAYERS-1:0] idx_onehot;
  logic                wr_en;

  // Input stream: a beat transfers on a cycle where in_valid && in_ready;
  // in_ready is high exactly while in LOAD and never depends on in_valid.
  assign in_ready = (state_q == ST_LOAD);
  assign wr_en    = in_ready && in_valid;

  always_comb begin
    idx_onehot              = '0;
    idx_onehot[layer_idx_q] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    layer_idx_d = layer_idx_q;
    loaded_d    = loaded_q;
    ack_d       = ack_q;
    layer_req_d = layer_req_q;
    case (state_q)
      ST_IDLE: begin
        if (fill) begin
          state_d   = ST_LOAD;
          wr_addr_d = '0;
          loaded_d  = 1'b0;
        end else if (req && loaded_q) begin
          state_d     = ST_RUN;
          layer_idx_d = '0;
          layer_req_d = N_LAYERS'(1);
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          if (wr_addr_q == LAST_ADDR) begin
            loaded_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
          end
        end
      end
      ST_RUN: begin
        // An all-zero request register marks the dead cycle between layers.
        if (layer_req_q == '0) begin
          layer_req_d = idx_onehot;
        end else if (layer_ack[layer_idx_q]) begin
          layer_req_d = '0;
          if (layer_idx_q == LAST_LAYER) begin
            state_d = ST_DONE;
            ack_d   = 1'b1;
          end else begin
            layer_idx_d = layer_idx_q + LIDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (!req) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_addr_q   <= '0;
      layer_idx_q <= '0;
      loaded_q    <= 1'b0;
      ack_q       <= 1'b0;
      layer_req_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      layer_idx_q <= layer_idx_d;
      loaded_q    <= loaded_d;
      ack_q       <= ack_d;
      layer_req_q <= layer_req_d;
    end
  end

  assign ack_network = ack_q;
  assign loaded      = loaded_q;
  assign layer_req   = layer_req_q;
  assign dbg_state   = state_q;

  nn_channel_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (N_INPUTS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (wr_en),
    .waddr_i (wr_addr_q),
    .wdata_i (in_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

endmodule
